cfi_alert_unit: RTL and testbench

// - Consumes the per-cycle CFI violation pulse and snapshot produced by the commit-stage CFI monitor.
// - Queues the violating commit PC and the FSM code for software/debug readout.
// - Counts violations and raises an interrupt request with an ack handshake.
// - Escalates to a sticky halt request once a programmable threshold is reached.
// - Sits between the CFI monitor and the CSR/debug logic of the ariane core.

---
 rtl/cfi_alert_unit.sv | 129 ++++++++++++
 tb/tb_cfi_alert_unit.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cfi_alert_unit.sv
// rtl/cfi_alert_unit.sv - CFI violation log FIFO, saturating counter and irq/halt escalation
module cfi_alert_unit #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned PC_W  = 64,
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             viol_valid_i,
  input  logic [PC_W-1:0]  viol_pc_i,
  input  logic [1:0]       viol_code_i,
  input  logic             clear_i,
  input  logic [CNT_W-1:0] thresh_i,
  output logic             log_valid_o,
  input  logic             log_ready_i,
  output logic [PC_W-1:0]  log_pc_o,
  output logic [1:0]       log_code_o,
  output logic             irq_o,
  input  logic             irq_ack_i,
  output logic             halt_req_o,
  output logic [CNT_W-1:0] viol_count_o,
  output logic             overflow_o
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PEND = 2'd1,
    HALT = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [AW:0]      wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             overflow_q, overflow_d;
  logic             irq_q, irq_d;
  logic             halt_q, halt_d;

  logic [PC_W-1:0]  pc_mem_q   [DEPTH];
  logic [1:0]       code_mem_q [DEPTH];

  logic             empty, full, pop, push, drop, thresh_hit;
  logic [CNT_W-1:0] count_inc;

  // Extra MSB on the pointers separates full (MSBs differ) from empty (equal).
  assign empty = (wptr_q == rptr_q);
  assign full  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);

  assign pop  = !empty && log_ready_i && !clear_i;
  assign push = viol_valid_i && !clear_i && (!full || pop);
  assign drop = viol_valid_i && !clear_i && full && !pop;

  assign count_inc  = (count_q == {CNT_W{1'b1}}) ? count_q : count_q + CNT_W'(1);
  assign thresh_hit = (thresh_i != '0) && viol_valid_i && (count_inc >= thresh_i);

  always_comb begin
    wptr_d     = wptr_q;
    rptr_d     = rptr_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    if (clear_i) begin
      wptr_d     = '0;
      rptr_d     = '0;
      count_d    = '0;
      overflow_d = 1'b0;
    end else begin
      if (push) wptr_d = wptr_q + (AW+1)'(1);
      if (pop)  rptr_d = rptr_q + (AW+1)'(1);
      if (drop) overflow_d = 1'b1;
      if (viol_valid_i) count_d = count_inc;
    end
  end

  always_comb begin
    state_d = state_q;
    if (clear_i) begin
      state_d = IDLE;
    end else if (thresh_hit) begin
      state_d = HALT;
    end else begin
      unique case (state_q)
        IDLE:    if (viol_valid_i) state_d = PEND;
        PEND:    if (irq_ack_i && !viol_valid_i) state_d = IDLE;
        HALT:    state_d = HALT;
        default: state_d = IDLE;
      endcase
    end
    irq_d  = (state_d == PEND) || (state_d == HALT);
    halt_d = (state_d == HALT);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      wptr_q     <= '0;
      rptr_q     <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      irq_q      <= 1'b0;
      halt_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      irq_q      <= irq_d;
      halt_q     <= halt_d;
    end
  end

  // Storage needs no reset: the head is masked whenever the FIFO is empty.
  always_ff @(posedge clk_i) begin
    if (push) begin
      pc_mem_q[wptr_q[AW-1:0]]   <= viol_pc_i;
      code_mem_q[wptr_q[AW-1:0]] <= viol_code_i;
    end
  end

  assign log_valid_o  = !empty;
  assign log_pc_o     = empty ? '0 : pc_mem_q[rptr_q[AW-1:0]];
  assign log_code_o   = empty ? '0 : code_mem_q[rptr_q[AW-1:0]];
  assign irq_o        = irq_q;
  assign halt_req_o   = halt_q;
  assign viol_count_o = count_q;
  assign overflow_o   = overflow_q;

endmodule

// File: tb/tb_cfi_alert_unit.sv
// tb/tb_cfi_alert_unit.sv - self-checking bench for cfi_alert_unit
module tb_cfi_alert_unit;

  localparam int DEPTH = 4;
  localparam int PC_W  = 64;
  localparam int CNT_W = 8;

  logic             clk_i = 1'b0;
  logic             rst_ni = 1'b0;
  logic             viol_valid_i = 1'b0;
  logic [PC_W-1:0]  viol_pc_i = '0;
  logic [1:0]       viol_code_i = '0;
  logic             clear_i = 1'b0;
  logic [CNT_W-1:0] thresh_i = '0;
  logic             log_valid_o;
  logic             log_ready_i = 1'b0;
  logic [PC_W-1:0]  log_pc_o;
  logic [1:0]       log_code_o;
  logic             irq_o;
  logic             irq_ack_i = 1'b0;
  logic             halt_req_o;
  logic [CNT_W-1:0] viol_count_o;
  logic             overflow_o;

  int checks = 0;
  int errors = 0;

  // Reference model: queue of logged entries plus plain integers/flags.
  logic [PC_W+1:0] mq[$];
  int              m_cnt;
  bit              m_ovf, m_irq, m_halt;

  cfi_alert_unit #(.DEPTH(DEPTH), .PC_W(PC_W), .CNT_W(CNT_W)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .viol_valid_i(viol_valid_i), .viol_pc_i(viol_pc_i), .viol_code_i(viol_code_i),
    .clear_i(clear_i), .thresh_i(thresh_i),
    .log_valid_o(log_valid_o), .log_ready_i(log_ready_i),
    .log_pc_o(log_pc_o), .log_code_o(log_code_o),
    .irq_o(irq_o), .irq_ack_i(irq_ack_i), .halt_req_o(halt_req_o),
    .viol_count_o(viol_count_o), .overflow_o(overflow_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic model_reset();
    mq.delete();
    m_cnt = 0; m_ovf = 0; m_irq = 0; m_halt = 0;
  endtask

  task automatic idle_inputs();
    viol_valid_i = 0; clear_i = 0; irq_ack_i = 0; log_ready_i = 0;
  endtask

  // Advance the model on the inputs currently applied, then clock the DUT.
  task automatic cycle();
    bit pop;
    int nc;
    pop = (mq.size() > 0) && log_ready_i;
    if (clear_i) begin
      model_reset();
    end else begin
      if (pop) void'(mq.pop_front());
      if (viol_valid_i) begin
        if (mq.size() < DEPTH) mq.push_back({viol_pc_i, viol_code_i});
        else m_ovf = 1;
        nc = (m_cnt + 1 > 255) ? 255 : m_cnt + 1;
        if (thresh_i != 0 && nc >= int'(thresh_i)) begin
          m_halt = 1; m_irq = 1;
        end else begin
          m_irq = 1;
        end
        m_cnt = nc;
      end else if (irq_ack_i && !m_halt) begin
        m_irq = 0;
      end
    end
    @(posedge clk_i);
    #1;
  endtask

  task automatic pulse(input logic [PC_W-1:0] pc, input logic [1:0] code);
    viol_valid_i = 1; viol_pc_i = pc; viol_code_i = code;
    cycle();
    viol_valid_i = 0;
  endtask

  task automatic do_clear();
    idle_inputs(); clear_i = 1; cycle(); clear_i = 0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_ni = 0; model_reset();
    #3;
    checks++;
    if ({log_valid_o, irq_o, halt_req_o, overflow_o} !== 4'b0) begin
      errors++; $display("FAIL reset_flags got %b want 0000", {log_valid_o, irq_o, halt_req_o, overflow_o});
    end
    checks++;
    if (viol_count_o !== '0) begin
      errors++; $display("FAIL reset_count got %0d want 0", viol_count_o);
    end
    @(negedge clk_i); rst_ni = 1;
    @(posedge clk_i); #1;
  endtask

  task automatic test_single_pulse();
    thresh_i = 0;
    pulse(64'h8000_0040, 2'd2);
    checks++;
    if (log_valid_o !== 1'b1 || log_pc_o !== 64'h8000_0040 || log_code_o !== 2'd2) begin
      errors++; $display("FAIL single_log got v=%b pc=%h code=%0d want v=1 pc=80000040 code=2", log_valid_o, log_pc_o, log_code_o);
    end
    checks++;
    if (irq_o !== 1'b1 || viol_count_o !== 8'd1) begin
      errors++; $display("FAIL single_irq_cnt got irq=%b cnt=%0d want irq=1 cnt=1", irq_o, viol_count_o);
    end
    irq_ack_i = 1; cycle(); irq_ack_i = 0;
    checks++;
    if (irq_o !== 1'b0) begin
      errors++; $display("FAIL single_ack got irq=%b want 0", irq_o);
    end
    log_ready_i = 1; cycle(); log_ready_i = 0;
    checks++;
    if (log_valid_o !== 1'b0) begin
      errors++; $display("FAIL single_drain got v=%b want 0", log_valid_o);
    end
  endtask

  task automatic test_overflow();
    logic [PC_W-1:0] pcs[5];
    do_clear();
    for (int i = 0; i < 5; i++) begin
      pcs[i] = {$urandom, $urandom};
      pulse(pcs[i], 2'(i));
    end
    checks++;
    if (overflow_o !== 1'b1 || viol_count_o !== 8'd5) begin
      errors++; $display("FAIL ovf_state got ovf=%b cnt=%0d want ovf=1 cnt=5", overflow_o, viol_count_o);
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (log_valid_o !== 1'b1 || log_pc_o !== pcs[i] || log_code_o !== 2'(i)) begin
        errors++; $display("FAIL ovf_pop%0d got v=%b pc=%h code=%0d want v=1 pc=%h code=%0d", i, log_valid_o, log_pc_o, log_code_o, pcs[i], i);
      end
      log_ready_i = 1; cycle(); log_ready_i = 0;
    end
    checks++;
    if (log_valid_o !== 1'b0) begin
      errors++; $display("FAIL ovf_empty got v=%b want 0", log_valid_o);
    end
  endtask

  task automatic test_back_to_back();
    logic [PC_W-1:0] pcs[5];
    do_clear();
    for (int i = 0; i < 5; i++) pcs[i] = {$urandom, $urandom};
    for (int i = 0; i < 4; i++) pulse(pcs[i], 2'd1);
    viol_valid_i = 1; viol_pc_i = pcs[4]; viol_code_i = 2'd3; log_ready_i = 1;
    cycle();
    idle_inputs();
    checks++;
    if (overflow_o !== 1'b0) begin
      errors++; $display("FAIL b2b_ovf got %b want 0", overflow_o);
    end
    for (int i = 1; i < 5; i++) begin
      checks++;
      if (log_valid_o !== 1'b1 || log_pc_o !== pcs[i]) begin
        errors++; $display("FAIL b2b_pop%0d got v=%b pc=%h want v=1 pc=%h", i, log_valid_o, log_pc_o, pcs[i]);
      end
      log_ready_i = 1; cycle(); log_ready_i = 0;
    end
    checks++;
    if (log_valid_o !== 1'b0) begin
      errors++; $display("FAIL b2b_empty got v=%b want 0", log_valid_o);
    end
  endtask

  task automatic test_threshold();
    do_clear();
    thresh_i = 8'd3;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (halt_req_o !== 1'b0) begin
        errors++; $display("FAIL thr_early%0d got halt=%b want 0", i, halt_req_o);
      end
      pulse({$urandom, $urandom}, 2'd0);
      if (i == 2) begin
        checks++;
        if (halt_req_o !== 1'b1 || irq_o !== 1'b1) begin
          errors++; $display("FAIL thr_halt got halt=%b irq=%b want 1 1", halt_req_o, irq_o);
        end
      end
      cycle();
    end
    irq_ack_i = 1; cycle(); irq_ack_i = 0;
    checks++;
    if (irq_o !== 1'b1 || halt_req_o !== 1'b1) begin
      errors++; $display("FAIL thr_ack got irq=%b halt=%b want 1 1", irq_o, halt_req_o);
    end
    do_clear();
    checks++;
    if ({irq_o, halt_req_o, log_valid_o, overflow_o} !== 4'b0 || viol_count_o !== '0) begin
      errors++; $display("FAIL thr_clear got flags=%b cnt=%0d want 0000 0", {irq_o, halt_req_o, log_valid_o, overflow_o}, viol_count_o);
    end
    thresh_i = 0;
  endtask

  task automatic test_ack_with_pulse();
    do_clear();
    pulse(64'h1000, 2'd1);
    viol_valid_i = 1; viol_pc_i = 64'h2000; irq_ack_i = 1;
    cycle();
    idle_inputs();
    checks++;
    if (irq_o !== 1'b1 || viol_count_o !== 8'd2) begin
      errors++; $display("FAIL ack_pulse got irq=%b cnt=%0d want irq=1 cnt=2", irq_o, viol_count_o);
    end
  endtask

  task automatic test_saturation();
    do_clear();
    thresh_i = 0;
    log_ready_i = 1;
    for (int i = 0; i < 260; i++) pulse({$urandom, $urandom}, 2'd0);
    checks++;
    if (viol_count_o !== 8'd255 || halt_req_o !== 1'b0) begin
      errors++; $display("FAIL sat_cnt got cnt=%0d halt=%b want 255 0", viol_count_o, halt_req_o);
    end
    thresh_i = 8'd255;
    pulse(64'h42, 2'd1);
    log_ready_i = 0;
    checks++;
    if (viol_count_o !== 8'd255 || halt_req_o !== 1'b1) begin
      errors++; $display("FAIL sat_halt got cnt=%0d halt=%b want 255 1", viol_count_o, halt_req_o);
    end
    thresh_i = 0;
    do_clear();
  endtask

  task automatic test_clear_and_reset();
    do_clear();
    pulse(64'hA0, 2'd1);
    pulse(64'hB0, 2'd2);
    viol_valid_i = 1; clear_i = 1; log_ready_i = 1; viol_pc_i = 64'hC0;
    cycle();
    idle_inputs();
    checks++;
    if (viol_count_o !== '0 || log_valid_o !== 1'b0 || irq_o !== 1'b0) begin
      errors++; $display("FAIL clr_pulse got cnt=%0d v=%b irq=%b want 0 0 0", viol_count_o, log_valid_o, irq_o);
    end
    thresh_i = 8'd2;
    viol_valid_i = 1; viol_pc_i = 64'hD0;
    cycle(); cycle(); cycle(); cycle(); cycle();
    rst_ni = 0; model_reset();
    #1;
    checks++;
    if ({log_valid_o, irq_o, halt_req_o, overflow_o} !== 4'b0 || viol_count_o !== '0) begin
      errors++; $display("FAIL async_rst got flags=%b cnt=%0d want 0000 0", {log_valid_o, irq_o, halt_req_o, overflow_o}, viol_count_o);
    end
    idle_inputs(); thresh_i = 0;
    @(negedge clk_i); rst_ni = 1;
    @(posedge clk_i); #1;
  endtask

  task automatic test_random();
    logic [PC_W+1:0] head;
    for (int n = 0; n < 1500; n++) begin
      viol_valid_i = ($urandom_range(0, 99) < 50);
      viol_pc_i    = {$urandom, $urandom};
      viol_code_i  = 2'($urandom);
      log_ready_i  = ($urandom_range(0, 99) < 40);
      irq_ack_i    = ($urandom_range(0, 99) < 25);
      clear_i      = ($urandom_range(0, 99) < 3);
      if ($urandom_range(0, 19) == 0) thresh_i = 8'($urandom_range(0, 12));
      cycle();
      checks++;
      if (log_valid_o !== (mq.size() > 0)) begin
        errors++; $display("FAIL rnd_valid n=%0d got %b want %b", n, log_valid_o, mq.size() > 0);
      end else if (mq.size() > 0) begin
        head = mq[0];
        checks++;
        if ({log_pc_o, log_code_o} !== head) begin
          errors++; $display("FAIL rnd_head n=%0d got %h want %h", n, {log_pc_o, log_code_o}, head);
        end
      end
      checks++;
      if (viol_count_o !== 8'(m_cnt)) begin
        errors++; $display("FAIL rnd_count n=%0d got %0d want %0d", n, viol_count_o, m_cnt);
      end
      checks++;
      if ({irq_o, halt_req_o, overflow_o} !== {m_irq, m_halt, m_ovf}) begin
        errors++; $display("FAIL rnd_flags n=%0d got irq/halt/ovf=%b want %b", n, {irq_o, halt_req_o, overflow_o}, {m_irq, m_halt, m_ovf});
      end
    end
    idle_inputs();
  endtask

  initial begin
    test_reset();
    test_single_pulse();
    test_overflow();
    test_back_to_back();
    test_threshold();
    test_ack_with_pulse();
    test_saturation();
    test_clear_and_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
